// File: rtl/load_store_unit.sv
// Purpose : load/store unit between execute and a fixed-latency memory port; one transaction at a time.
// Latency : aligned access responds MEM_LATENCY+1 cycles after acceptance; a misaligned access responds after 1 cycle.
// Backpres: oReqReady is high only in IDLE; a response is held in RESP until iRespReady.
//
// Ports:
//   iClock, iReset                        clock, synchronous active-high reset
//   iReqValid/oReqReady                   request handshake; iReqWr, iReqAddr, iReqData, iReqSize, iReqUnsigned
//   oRespValid/iRespReady                 response handshake; oRespData (extended load data), oRespErr (misaligned)
//   oMemRdEn, oMemRdAddrLoad, iMemRdDataLoad                    doubleword-aligned read port
//   oMemWrEn, oMemWrAddr, oMemWrData, oMemWrLen                 byte-addressed write port
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWr,
  input  logic [63:0] iReqAddr,
  input  logic [63:0] iReqData,
  input  logic [1:0]  iReqSize,
  input  logic        iReqUnsigned,
  output logic        oRespValid,
  input  logic        iRespReady,
  output logic [63:0] oRespData,
  output logic        oRespErr,
  output logic        oMemRdEn,
  output logic [63:0] oMemRdAddrLoad,
  input  logic [63:0] iMemRdDataLoad,
  output logic        oMemWrEn,
  output logic [63:0] oMemWrAddr,
  output logic [63:0] oMemWrData,
  output logic [7:0]  oMemWrLen
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 1);

  state_t      state;
  logic [7:0]  cnt;       // remaining ACCESS cycles after the current one
  logic        wr_q;
  logic [2:0]  lane_q;    // byte lane within the doubleword
  logic [1:0]  size_q;
  logic        uns_q;

  logic        misaligned;
  logic [63:0] shifted;
  logic [63:0] load_ext;
  logic [7:0]  wr_len;

  assign oReqReady = (state == IDLE) && !iReset;

  // Misaligned when any address bit below log2(size in bytes) is set.
  always_comb begin
    misaligned = 1'b0;
    case (iReqSize)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = iReqAddr[0];
      2'd2:    misaligned = |iReqAddr[1:0];
      default: misaligned = |iReqAddr[2:0];
    endcase
  end

  always_comb begin
    wr_len = 8'd0;
    case (iReqSize)
      2'd0:    wr_len = 8'd1;
      2'd1:    wr_len = 8'd2;
      2'd2:    wr_len = 8'd4;
      default: wr_len = 8'd8;
    endcase
  end

  // Move the addressed lane to bit 0, then truncate and extend to the access size.
  assign shifted = iMemRdDataLoad >> {lane_q, 3'b000};

  always_comb begin
    load_ext = 64'd0;
    case (size_q)
      2'd0:    load_ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    load_ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      wr_q           <= 1'b0;
      lane_q         <= 3'd0;
      size_q         <= 2'd0;
      uns_q          <= 1'b0;
      oRespValid     <= 1'b0;
      oRespData      <= 64'd0;
      oRespErr       <= 1'b0;
      oMemRdEn       <= 1'b0;
      oMemRdAddrLoad <= 64'd0;
      oMemWrEn       <= 1'b0;
      oMemWrAddr     <= 64'd0;
      oMemWrData     <= 64'd0;
      oMemWrLen      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (iReqValid) begin
            wr_q   <= iReqWr;
            lane_q <= iReqAddr[2:0];
            size_q <= iReqSize;
            uns_q  <= iReqUnsigned;
            if (misaligned) begin
              // No memory traffic; report the error straight away.
              state      <= RESP;
              oRespValid <= 1'b1;
              oRespErr   <= 1'b1;
              oRespData  <= 64'd0;
            end else begin
              state <= ACCESS;
              cnt   <= CNT_LOAD;
              if (iReqWr) begin
                // Write is a single-cycle pulse in the first ACCESS cycle.
                oMemWrEn   <= 1'b1;
                oMemWrAddr <= iReqAddr;
                oMemWrData <= iReqData;
                oMemWrLen  <= wr_len;
              end else begin
                oMemRdEn       <= 1'b1;
                oMemRdAddrLoad <= {iReqAddr[63:3], 3'b000};
              end
            end
          end
        end

        ACCESS: begin
          oMemWrEn <= 1'b0;
          if (cnt == 8'd0) begin
            state      <= RESP;
            oMemRdEn   <= 1'b0;
            oRespValid <= 1'b1;
            oRespErr   <= 1'b0;
            oRespData  <= wr_q ? 64'd0 : load_ext;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        RESP: begin
          if (iRespReady) begin
            state      <= IDLE;
            oRespValid <= 1'b0;
            oRespData  <= 64'd0;
            oRespErr   <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          oMemRdEn   <= 1'b0;
          oMemWrEn   <= 1'b0;
          oRespValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : bench for load_store_unit with two instances, MEM_LATENCY=1 and MEM_LATENCY=3.
// Latency : n/a (bench).
// Backpres: drives iRespReady low for a chosen number of cycles per transaction.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [2];
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_wr      [2];
  logic [63:0] req_addr    [2];
  logic [63:0] req_data    [2];
  logic [1:0]  req_size    [2];
  logic        req_uns     [2];
  logic        resp_valid  [2];
  logic        resp_ready  [2];
  logic [63:0] resp_data   [2];
  logic        resp_err    [2];
  logic        mem_rd_en   [2];
  logic [63:0] mem_rd_addr [2];
  logic [63:0] mem_rd_data [2];
  logic        mem_wr_en   [2];
  logic [63:0] mem_wr_addr [2];
  logic [63:0] mem_wr_data [2];
  logic [7:0]  mem_wr_len  [2];

  int vectors     = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    load_store_unit #(.MEM_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .iClock         (clk),
      .iReset         (rst[g]),
      .iReqValid      (req_valid[g]),
      .oReqReady      (req_ready[g]),
      .iReqWr         (req_wr[g]),
      .iReqAddr       (req_addr[g]),
      .iReqData       (req_data[g]),
      .iReqSize       (req_size[g]),
      .iReqUnsigned   (req_uns[g]),
      .oRespValid     (resp_valid[g]),
      .iRespReady     (resp_ready[g]),
      .oRespData      (resp_data[g]),
      .oRespErr       (resp_err[g]),
      .oMemRdEn       (mem_rd_en[g]),
      .oMemRdAddrLoad (mem_rd_addr[g]),
      .iMemRdDataLoad (mem_rd_data[g]),
      .oMemWrEn       (mem_wr_en[g]),
      .oMemWrAddr     (mem_wr_addr[g]),
      .oMemWrData     (mem_wr_data[g]),
      .oMemWrLen      (mem_wr_len[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: byte address modulo access size must be zero.
  function automatic bit is_misaligned(input logic [63:0] addr, input logic [1:0] size);
    longint unsigned nbytes;
    nbytes = 64'd1 << size;
    return (addr % nbytes) != 0;
  endfunction

  // Reference load result: take nbytes starting at byte addr%8 of the doubleword, then extend.
  function automatic logic [63:0] load_model(input logic [63:0] rd, input logic [63:0] addr,
                                              input logic [1:0] size, input bit uns);
    int          nbytes;
    int          lane;
    logic [63:0] v;
    logic [63:0] mask;
    nbytes = 1 << size;
    lane   = int'(addr % 8);
    v      = rd >> (8 * lane);
    mask   = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * nbytes)) - 64'd1);
    v      = v & mask;
    if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
    return v;
  endfunction

  // One complete transaction, entered and left at a negedge with the DUT idle.
  task automatic txn(input int d, input bit wr, input logic [63:0] addr, input logic [63:0] data,
                     input logic [1:0] size, input bit uns, input int hold,
                     input bit fixed, input logic [63:0] fixed_rd);
    int          n;
    bit          mis;
    logic [63:0] last_rd;
    logic [63:0] exp_d;
    mis     = is_misaligned(addr, size);
    last_rd = 64'd0;
    chk("ready_idle", 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_data[d]  = data;
    req_size[d]  = size;
    req_uns[d]   = uns;
    @(negedge clk);
    // Request fields are scrambled after acceptance; only the captured copy may matter.
    req_wr[d]   = 1'($urandom);
    req_addr[d] = rnd64();
    req_data[d] = rnd64();
    req_size[d] = 2'($urandom);
    req_uns[d]  = 1'($urandom);
    n = 1;
    while (!resp_valid[d] && n <= lat(d) + 2) begin
      chk("ready_busy", 64'(req_ready[d]), 64'd0);
      chk("rd_en", 64'(mem_rd_en[d]), 64'(!wr && !mis));
      chk("wr_en", 64'(mem_wr_en[d]), 64'(wr && !mis && n == 1));
      if (!wr) chk("rd_addr", mem_rd_addr[d], addr & ~64'd7);
      if (wr && n == 1) begin
        chk("wr_addr", mem_wr_addr[d], addr);
        chk("wr_data", mem_wr_data[d], data);
        chk("wr_len", 64'(mem_wr_len[d]), 64'd1 << size);
      end
      last_rd        = fixed ? fixed_rd : rnd64();
      mem_rd_data[d] = last_rd;
      req_valid[d]   = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), mis ? 64'd1 : 64'(lat(d) + 1));
    exp_d = (mis || wr) ? 64'd0 : load_model(last_rd, addr, size, uns);
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", 64'(resp_valid[d]), 64'd1);
      chk("resp_data", resp_data[d], exp_d);
      chk("resp_err", 64'(resp_err[d]), 64'(mis));
      chk("ready_resp", 64'(req_ready[d]), 64'd0);
      chk("rd_en_resp", 64'(mem_rd_en[d]), 64'd0);
      chk("wr_en_resp", 64'(mem_wr_en[d]), 64'd0);
      mem_rd_data[d] = rnd64();
      req_valid[d]   = 1'($urandom);
      if (h == hold) resp_ready[d] = 1'b1;
      @(negedge clk);
    end
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    chk("resp_drop", 64'(resp_valid[d]), 64'd0);
    chk("ready_after", 64'(req_ready[d]), 64'd1);
  endtask

  // Store on the MEM_LATENCY=3 instance, reset during its 2nd ACCESS cycle.
  task automatic reset_mid_store();
    logic [63:0] data;
    data = rnd64();
    chk("rst_ready_pre", 64'(req_ready[1]), 64'd1);
    req_valid[1] = 1'b1;
    req_wr[1]    = 1'b1;
    req_addr[1]  = 64'h80000020;
    req_data[1]  = data;
    req_size[1]  = 2'd3;
    req_uns[1]   = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rst_wr_first", 64'(mem_wr_en[1]), 64'd1);
    @(negedge clk);
    chk("rst_wr_second", 64'(mem_wr_en[1]), 64'd0);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", 64'(req_ready[1]), 64'd0);
    chk("rst_wr_en", 64'(mem_wr_en[1]), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid[1]), 64'd0);
    chk("rst_wr_addr", mem_wr_addr[1], 64'd0);
    chk("rst_wr_len", 64'(mem_wr_len[1]), 64'd0);
    rst[1] = 1'b0;
    #1;
    chk("rst_ready_first", 64'(req_ready[1]), 64'd1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_resp", 64'(resp_valid[1]), 64'd0);
      chk("rst_no_write", 64'(mem_wr_en[1]), 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]         = 1'b1;
      req_valid[d]   = 1'b0;
      req_wr[d]      = 1'b0;
      req_addr[d]    = 64'd0;
      req_data[d]    = 64'd0;
      req_size[d]    = 2'd0;
      req_uns[d]     = 1'b0;
      resp_ready[d]  = 1'b0;
      mem_rd_data[d] = 64'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 64'(req_ready[d]), 64'd0);
      chk("reset_resp_valid", 64'(resp_valid[d]), 64'd0);
      chk("reset_resp_data", resp_data[d], 64'd0);
      chk("reset_rd_en", 64'(mem_rd_en[d]), 64'd0);
      chk("reset_wr_en", 64'(mem_wr_en[d]), 64'd0);
      chk("reset_wr_len", 64'(mem_wr_len[d]), 64'd0);
      rst[d] = 1'b0;
    end
    @(negedge clk);

    // Directed cases.
    txn(0, 1'b0, 64'h80000003, 64'd0, 2'd0, 1'b0, 0, 1'b1, 64'h00000000_80FF0000);
    txn(0, 1'b0, 64'h80000004, 64'd0, 2'd2, 1'b1, 0, 1'b1, 64'h89ABCDEF_01234567);
    txn(0, 1'b1, 64'h80000010, 64'h1234, 2'd1, 1'b0, 0, 1'b0, 64'd0);
    txn(0, 1'b0, 64'h80000002, 64'd0, 2'd2, 1'b0, 0, 1'b0, 64'd0);
    txn(1, 1'b0, 64'h8000000B, 64'd0, 2'd0, 1'b0, 4, 1'b0, 64'd0);
    txn(1, 1'b0, 64'h80000008, 64'd0, 2'd3, 1'b0, 4, 1'b0, 64'd0);
    reset_mid_store();

    // Randomized traffic on both instances.
    for (int i = 0; i < 200; i++) begin
      int          d;
      logic [1:0]  size;
      logic [63:0] addr;
      d    = i % 2;
      size = 2'($urandom);
      addr = rnd64();
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      txn(d, 1'($urandom), addr, rnd64(), size, 1'($urandom), $urandom_range(0, 3), 1'b0, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
